// File: rtl/exe_muldiv_seq_pkg.sv
// Shared definitions for the EXE-stage multiply/divide sequencer:
// operation codes, FSM state encoding and the default operand width.
package exe_muldiv_seq_pkg;

   localparam int MD_WIDTH = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_RUN  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } md_state_e;

endpackage : exe_muldiv_seq_pkg

// File: rtl/exe_muldiv_seq_if.sv
// Request/result bundle between the EXE stage (master) and the
// multiply/divide sequencer (slave).
interface exe_muldiv_seq_if
   import exe_muldiv_seq_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
);
   logic             start;
   md_op_e           op;
   logic [WIDTH-1:0] eqa;
   logic [WIDTH-1:0] eqb;
   logic             cancel;
   logic             stall;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, eqa, eqb, cancel,
      input  stall, busy, done, hi, lo
   );

   modport slave (
      input  start, op, eqa, eqb, cancel,
      output stall, busy, done, hi, lo
   );
endinterface : exe_muldiv_seq_if

// File: rtl/exe_muldiv_seq_step.sv
// One iteration of the sequencer datapath. In multiply mode it does a
// right-shifting shift-add on {acc, q} (q holds the multiplier); in divide
// mode it does a restoring shift-subtract (q holds the dividend and collects
// quotient bits, acc holds the partial remainder).
module exe_muldiv_seq_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic             div_mode_i,
   input  logic [WIDTH-1:0] operand_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] shifted;

   // Single multiply or divide iteration, selected by div_mode_i.
   always_comb begin
      // NOTE: every output gets a default first, so no path can leave one unassigned and infer a latch.
      acc_o   = acc_i;
      q_o     = q_i;
      sum     = {1'b0, acc_i} + {1'b0, operand_i};
      // Partial remainder shifted left with the next dividend bit; the MSB of
      // acc is kept as the extra top bit so the subtraction cannot overflow.
      diff    = {acc_i, q_i[WIDTH-1]} - {1'b0, operand_i};
      shifted = {acc_i[WIDTH-2:0], q_i[WIDTH-1]};
      if (div_mode_i) begin
         if (!diff[WIDTH]) begin
            acc_o = diff[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = shifted;
            q_o   = {q_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (q_i[0]) begin
            {acc_o, q_o} = {sum, q_i[WIDTH-1:1]};
         end else begin
            {acc_o, q_o} = {1'b0, acc_i, q_i[WIDTH-1:1]};
         end
      end
   end

endmodule : exe_muldiv_seq_step

// File: rtl/exe_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer beside the EXE-stage ALU.
// IDLE -> PREP -> RUN (WIDTH steps) -> FIX -> DONE -> IDLE; the pipeline is
// stalled from the request cycle until DONE, and hi/lo change only in FIX.
module exe_muldiv_seq
   import exe_muldiv_seq_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clock,
   input  logic             resetn,
   exe_muldiv_seq_if.slave  md
);

   localparam int CNT_W = $clog2(WIDTH);

   md_state_e          state_q, state_d;
   md_op_e             op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   bmag_q, bmag_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   qr_q, qr_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               dz_q, dz_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               is_div;
   logic               is_signed;
   logic               busy;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   step_acc;
   logic [WIDTH-1:0]   step_q;
   logic [2*WIDTH-1:0] prod_mag;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign is_div    = op_q[1];
   assign is_signed = ~op_q[0];

   // Signed ops iterate on magnitudes; the signs are reapplied in FIX.
   assign a_mag = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
   assign b_mag = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

   assign prod_mag = {acc_q, qr_q};
   assign prod_fix = neg_res_q ? -prod_mag : prod_mag;
   assign quo_fix  = neg_res_q ? -qr_q : qr_q;
   assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

   exe_muldiv_seq_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc_i      (acc_q),
      .q_i        (qr_q),
      .div_mode_i (is_div),
      .operand_i  (bmag_q),
      .acc_o      (step_acc),
      .q_o        (step_q)
   );

   // Next-state and datapath update for every FSM state.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      bmag_d    = bmag_q;
      acc_d     = acc_q;
      qr_d      = qr_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      cnt_d     = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (md.start) begin
               op_d    = md.op;
               a_d     = md.eqa;
               b_d     = md.eqb;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            neg_res_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            neg_rem_d = is_signed & a_q[WIDTH-1];
            dz_d      = is_div & (b_q == '0);
            qr_d      = a_mag;
            bmag_d    = b_mag;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = S_RUN;
         end
         S_RUN: begin
            acc_d = step_acc;
            qr_d  = step_q;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FIX: begin
            if (is_div) begin
               // Divide by zero keeps the full latency and returns all-ones / original dividend.
               hi_d = dz_q ? a_q : rem_fix;
               lo_d = dz_q ? '1  : quo_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A flush aborts the op in flight without touching hi/lo.
      if (md.cancel && (state_q inside {S_PREP, S_RUN, S_FIX})) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         // NOTE: non-blocking (<=) so every register samples pre-edge values regardless of statement order.
         state_q   <= S_IDLE;
         op_q      <= MD_MULT;
         a_q       <= '0;
         b_q       <= '0;
         bmag_q    <= '0;
         acc_q     <= '0;
         qr_q      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         bmag_q    <= bmag_d;
         acc_q     <= acc_d;
         qr_q      <= qr_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         cnt_q     <= cnt_d;
      end
   end

   assign busy     = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
   assign md.busy  = busy;
   assign md.stall = ((state_q == S_IDLE) && md.start) || busy;
   assign md.done  = (state_q == S_DONE);
   assign md.hi    = hi_q;
   assign md.lo    = lo_q;

endmodule : exe_muldiv_seq

// File: tb/tb_exe_muldiv_seq.sv
// Self-checking bench for exe_muldiv_seq: a latency-counting reference model
// with plain arithmetic results is compared against the DUT every cycle, and
// directed operations are checked against hand-computed literals.
module tb_exe_muldiv_seq;
   import exe_muldiv_seq_pkg::*;

   localparam int W       = 32;
   localparam int LAT     = W + 3;   // request cycle to done cycle
   localparam int LAST_BZ = W + 2;   // last busy cycle count after acceptance

   logic clock;
   logic resetn;
   int   n_vec = 0;
   int   n_err = 0;

   exe_muldiv_seq_if #(.WIDTH(W)) md ();

   exe_muldiv_seq #(.WIDTH(W)) dut (
      .clock  (clock),
      .resetn (resetn),
      .md     (md)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result {hi, lo} from plain arithmetic.
   function automatic logic [63:0] ref_result(input md_op_e op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, qv, rv;
      logic [63:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = '0;
      case (op)
         MD_MULTU: r = {32'h0, a} * {32'h0, b};
         MD_MULT:  r = sa * sb;
         MD_DIVU:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         MD_DIV: begin
            if (b == 0) begin
               r = {a, 32'hFFFF_FFFF};
            end else begin
               qv = sa / sb;
               rv = sa % sb;
               r  = {rv[31:0], qv[31:0]};
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // Reference model: counts cycles since acceptance instead of tracking states.
   int          m_n    = 0;
   bit          m_live = 0;
   logic [31:0] m_hi = '0, m_lo = '0, m_res_hi = '0, m_res_lo = '0;

   always @(posedge clock) begin
      if (!resetn) begin
         m_n = 0; m_hi = '0; m_lo = '0; m_live = 1;
      end else if (m_n == 0) begin
         if (md.start) begin
            m_n = 1;
            {m_res_hi, m_res_lo} = ref_result(md.op, md.eqa, md.eqb);
         end
      end else if (m_n <= LAST_BZ) begin
         if (md.cancel) begin
            m_n = 0;
         end else begin
            m_n++;
            if (m_n == LAT) begin
               m_hi = m_res_hi;
               m_lo = m_res_lo;
            end
         end
      end else begin
         m_n = 0;
      end
   end

   // Per-cycle comparison of all outputs against the model.
   always @(negedge clock) begin
      if (m_live) begin
         check("cyc_busy",  32'(md.busy),  32'((m_n >= 1) && (m_n <= LAST_BZ)));
         check("cyc_stall", 32'(md.stall), 32'(((m_n == 0) && md.start) || ((m_n >= 1) && (m_n <= LAST_BZ))));
         check("cyc_done",  32'(md.done),  32'(m_n == LAT));
         check("cyc_hi",    md.hi, m_hi);
         check("cyc_lo",    md.lo, m_lo);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic launch(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
      md.op = op; md.eqa = a; md.eqb = b; md.start = 1'b1;
   endtask

   // Called in the request cycle; returns one cycle after done.
   task automatic wait_done(input string name, input bit hold, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo);
      int cyc = 0;
      bit got = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (md.done) begin
            got = 1;
            break;
         end
         tick();
         cyc++;
         if (!hold) begin
            md.start = 1'b0;
            md.eqa   = $urandom;
            md.eqb   = $urandom;
            md.op    = md_op_e'(2'($urandom_range(0, 3)));
         end
      end
      check({name, "_latency"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(LAT));
      check({name, "_hi"}, md.hi, exp_hi);
      check({name, "_lo"}, md.lo, exp_lo);
      tick();
   endtask

   task automatic do_op(input string name, input md_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      launch(op, a, b);
      wait_done(name, 1'b0, exp_hi, exp_lo);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n_done;
      logic [63:0] pin;

      // Pin the model itself with hand-computed values.
      pin = ref_result(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("pin_multu_hi", pin[63:32], 32'hFFFF_FFFE);
      check("pin_multu_lo", pin[31:0],  32'h0000_0001);
      pin = ref_result(MD_MULT, 32'hFFFF_FFFB, 32'd7);
      check("pin_mult_lo", pin[31:0], 32'hFFFF_FFDD);
      pin = ref_result(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      check("pin_div_hi", pin[63:32], 32'hFFFF_FFFF);
      check("pin_div_lo", pin[31:0],  32'hFFFF_FFFD);
      pin = ref_result(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      check("pin_ovf_lo", pin[31:0], 32'h8000_0000);

      resetn = 1'b0; md.start = 1'b0; md.cancel = 1'b0;
      md.op = MD_MULT; md.eqa = '0; md.eqb = '0;
      repeat (3) tick();
      @(negedge clock);
      check("rst_hi",    md.hi, 32'h0);
      check("rst_lo",    md.lo, 32'h0);
      check("rst_busy",  32'(md.busy),  32'h0);
      check("rst_stall", 32'(md.stall), 32'h0);
      check("rst_done",  32'(md.done),  32'h0);
      tick();
      resetn = 1'b1;
      tick();

      // Main function, signed fixes, overflow and divide-by-zero.
      do_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      do_op("mult_neg",  MD_MULT,  32'hFFFF_FFFB, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFDD);
      do_op("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      do_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      do_op("divu_z",    MD_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
      do_op("div_z",     MD_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
      do_op("mult_min",  MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      do_op("divu_1000", MD_DIVU,  32'd1000,      32'd7,         32'd6,         32'd142);
      do_op("div_pos",   MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);

      // Cancel at cycle 10 of a DIVU: back to IDLE at 11, no done, hi/lo untouched.
      launch(MD_DIVU, 32'd1000, 32'd7);
      tick();
      md.start = 1'b0;
      repeat (9) tick();
      md.cancel = 1'b1;
      tick();
      md.cancel = 1'b0;
      @(negedge clock);
      check("cancel_stall", 32'(md.stall), 32'h0);
      check("cancel_busy",  32'(md.busy),  32'h0);
      n_done = 0;
      for (int i = 0; i < 45; i++) begin
         tick();
         @(negedge clock);
         if (md.done) n_done++;
      end
      check("cancel_no_done", 32'(n_done), 32'h0);
      check("cancel_hi", md.hi, 32'd1);
      check("cancel_lo", md.lo, 32'hFFFF_FFFD);
      tick();

      // Reset in cycle 20 of MULTU 3*4 discards everything.
      launch(MD_MULTU, 32'd3, 32'd4);
      tick();
      md.start = 1'b0;
      repeat (19) tick();
      resetn = 1'b0;
      tick();
      @(negedge clock);
      check("mid_rst_hi",    md.hi, 32'h0);
      check("mid_rst_lo",    md.lo, 32'h0);
      check("mid_rst_busy",  32'(md.busy),  32'h0);
      check("mid_rst_stall", 32'(md.stall), 32'h0);
      check("mid_rst_done",  32'(md.done),  32'h0);
      tick();
      resetn = 1'b1;
      tick();
      do_op("multu_3x4", MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

      // start held through RUN and DONE; the next op begins only in IDLE, back to back.
      launch(MD_MULTU, 32'd5, 32'd6);
      wait_done("hold_first", 1'b1, 32'd0, 32'd30);
      md.op = MD_MULT; md.eqa = 32'hFFFF_FFFD; md.eqb = 32'd9;
      wait_done("hold_second", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFE5);

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_exe_muldiv_seq
